// File: rtl/set_assoc_icache.sv
// Read-only set-associative instruction cache: one lookup per cycle, single outstanding
// miss refilled as a multi-beat line, per-set round-robin replacement and whole-cache flush.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// LOOKUP   | accept requests; compare the previous accept against all ways
// MISS_REQ | hold the line request on the memory side until accepted
// REFILL   | write returning beats into the victim way
// RESPOND  | return the requested word of the freshly filled line
module set_assoc_icache #(
  parameter int WAYS         = 2,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 6,
  parameter int MEM_WIDTH    = 32
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 ReqValid,
  input  logic [31:0]          ReqAddress,
  output logic                 ReqReady,
  output logic                 RespValid,
  output logic [31:0]          Instruction,
  input  logic                 Flush,
  output logic                 MemReqValid,
  output logic [31:0]          MemReqAddress,
  input  logic                 MemReqReady,
  input  logic                 MemRespValid,
  input  logic [MEM_WIDTH-1:0] MemRespData
);
  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS      = 2 ** INDEX_WIDTH;
  localparam int BEATS     = (2 ** OFFSET_WIDTH) * 8 / MEM_WIDTH;
  localparam int WPB       = MEM_WIDTH / 32;
  localparam int WPB_LOG   = $clog2(WPB);
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WIB_W     = (WPB > 1) ? WPB_LOG : 1;

  typedef enum logic [1:0] {LOOKUP, MISS_REQ, REFILL, RESPOND} state_t;
  state_t state_q, state_d;

  logic [TAG_WIDTH-1:0] tag_mem  [WAYS][SETS];
  logic [MEM_WIDTH-1:0] data_mem [WAYS][SETS][BEATS];
  logic [WAYS-1:0]      valid_q  [SETS];
  logic [WAY_W-1:0]     rr_q     [SETS];

  logic [TAG_WIDTH-1:0] rd_tag  [WAYS];
  logic [MEM_WIDTH-1:0] rd_beat [WAYS];

  logic [TAG_WIDTH-1:0]    tag_q, req_tag;
  logic [INDEX_WIDTH-1:0]  idx_q, req_idx;
  logic [BEAT_W-1:0]       beat_q, req_beat, beat_cnt_q;
  logic [WIB_W-1:0]        wib_q, req_wib;
  logic [OFFSET_WIDTH-1:0] req_word;
  logic                    pend_q, flush_pend_q, victim_rr_q, victim_rr_d;
  logic [WAY_W-1:0]        victim_q, victim_d, hit_way;
  logic [31:0]             resp_word_q, instr_q, lookup_word;
  logic                    accept, hit, miss, last_beat;

  assign req_tag  = ReqAddress[31 -: TAG_WIDTH];
  assign req_idx  = ReqAddress[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word = ReqAddress[OFFSET_WIDTH-1:0] >> 2;
  assign req_beat = BEAT_W'(req_word >> WPB_LOG);
  assign req_wib  = (WPB > 1) ? WIB_W'(req_word) : '0;

  assign accept    = ReqValid && ReqReady;
  assign miss      = (state_q == LOOKUP) && pend_q && !hit;
  assign last_beat = MemRespValid && (beat_cnt_q == BEAT_W'(BEATS - 1));
  assign MemReqAddress = {tag_q, idx_q, {OFFSET_WIDTH{1'b0}}};

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_q][w] && (rd_tag[w] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    lookup_word = rd_beat[hit_way][32*int'(wib_q) +: 32];
  end

  // Lowest-index invalid way wins; only a full set falls back to the pointer.
  always_comb begin
    victim_d    = rr_q[idx_q];
    victim_rr_d = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_q][w]) begin
        victim_d    = WAY_W'(w);
        victim_rr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= LOOKUP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ReqReady    = 1'b0;
    RespValid   = 1'b0;
    MemReqValid = 1'b0;
    Instruction = instr_q;
    case (state_q)
      LOOKUP: begin
        if (miss) begin
          state_d = MISS_REQ;
        end else begin
          ReqReady  = !flush_pend_q;
          RespValid = pend_q;
          if (pend_q) Instruction = lookup_word;
        end
      end
      MISS_REQ: begin
        MemReqValid = 1'b1;
        if (MemReqReady) state_d = REFILL;
      end
      REFILL: begin
        if (last_beat) state_d = RESPOND;
      end
      RESPOND: begin
        RespValid   = 1'b1;
        Instruction = resp_word_q;
        state_d     = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
    if (Reset) begin
      ReqReady    = 1'b0;
      RespValid   = 1'b0;
      MemReqValid = 1'b0;
      Instruction = instr_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (accept) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_tag[w]  <= tag_mem[w][req_idx];
        rd_beat[w] <= data_mem[w][req_idx][req_beat];
      end
    end
    if (!Reset && (state_q == REFILL) && MemRespValid) begin
      data_mem[victim_q][idx_q][beat_cnt_q] <= MemRespData;
      if (last_beat) tag_mem[victim_q][idx_q] <= tag_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pend_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      beat_cnt_q   <= '0;
      victim_q     <= '0;
      victim_rr_q  <= 1'b0;
      instr_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      pend_q  <= accept;
      instr_q <= Instruction;
      if (accept) begin
        tag_q  <= req_tag;
        idx_q  <= req_idx;
        beat_q <= req_beat;
        wib_q  <= req_wib;
      end
      case (state_q)
        LOOKUP: begin
          if (Flush || flush_pend_q) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          end
          flush_pend_q <= 1'b0;
          if (miss) begin
            victim_q    <= victim_d;
            victim_rr_q <= victim_rr_d;
            beat_cnt_q  <= '0;
          end
        end
        REFILL: begin
          if (Flush) flush_pend_q <= 1'b1;
          if (MemRespValid) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            if (beat_cnt_q == beat_q) resp_word_q <= MemRespData[32*int'(wib_q) +: 32];
            if (last_beat) begin
              valid_q[idx_q][victim_q] <= 1'b1;
              if (victim_rr_q)
                rr_q[idx_q] <= (rr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_q] + WAY_W'(1);
            end
          end
        end
        default: if (Flush) flush_pend_q <= 1'b1;
      endcase
    end
  end
endmodule
